state_app_dispatcher: RTL and testbench
=======================================

Name: state_app_dispatcher

Overview:
- Initiator side of the state-lookup application interface. Sits in the state_processor between the flow-table result path and one state lookup app.
- Accepts one packet's match field, action and source port on a valid/ready input. Issues a single-cycle lookup request to the app and waits for app_done.
- Captures the app's modified action and source port, then presents them downstream on a valid/ready output.
- Enforces one outstanding request at a time, because the app holds only one context. A timeout guarantees forward progress.

Parameters:
- ST_WIDTH, 64, match field width sent to the app.
- ACTION_WIDTH, `OPENFLOW_ACTION_WIDTH, action bus width.
- SRC_PORT_WIDTH, `OPENFLOW_ENTRY_SRC_PORT_WIDTH, flow entry source port width.
- TIMEOUT_CYCLES, 64, number of WAIT cycles without app_done before the request is abandoned.
- TO_CNT_WIDTH, log2(TIMEOUT_CYCLES)+1, timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_match_field  in  ST_WIDTH  upstream match field
- in_action  in  ACTION_WIDTH  upstream action
- in_src_port  in  SRC_PORT_WIDTH  upstream source port
- in_vld  in  1  upstream valid
- in_rdy  out  1  upstream ready
- match_field  out  ST_WIDTH  to app
- match_field_vld  out  1  to app; one-cycle request pulse
- action_in  out  ACTION_WIDTH  to app
- flow_entry_src_port  out  SRC_PORT_WIDTH  to app
- app_done  in  1  from app; one-cycle completion pulse
- app_action  in  ACTION_WIDTH  from app's action_out
- app_src_port  in  SRC_PORT_WIDTH  from app's flow_entry_src_port_out
- out_action  out  ACTION_WIDTH  downstream action
- out_src_port  out  SRC_PORT_WIDTH  downstream source port
- out_timeout  out  1  set when the result is an unmodified pass-through caused by timeout
- out_vld  out  1  downstream valid
- out_rdy  in  1  downstream ready

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, OUT. On reset the FSM enters IDLE.
- Reset values: all outputs and registers 0, except in_rdy=1.
- in_rdy=1 only in IDLE.
- IDLE: on in_vld&in_rdy, latch field, action and port into the context registers, then go to ISSUE.
- ISSUE: lasts exactly 1 cycle.
  - match_field_vld=1; match_field, action_in and flow_entry_src_port are driven from the context.
  - Clear the timeout counter, then go to WAIT.
- Context registers drive match_field, action_in and flow_entry_src_port continuously, in all states.
- WAIT: the timeout counter increments each cycle.
  - If app_done=1: register app_action into out_action and app_src_port into out_src_port, set out_timeout=0, and go to OUT.
  - Else if counter==TIMEOUT_CYCLES-1: set out_action and out_src_port from the context, set out_timeout=1, and go to OUT.
  - If app_done and expiry occur in the same cycle, app_done wins.
- Minimum latency is 3 cycles from the input handshake to out_vld, assuming the app answers in the cycle after the request.
- OUT: out_vld=1, and the output registers are held stable.
  - On out_rdy, go to IDLE.
  - out_rdy may be high on out_vld's first cycle; the FSM then returns to IDLE on the next edge.
- app_done is sampled only in WAIT. A done in IDLE, ISSUE or OUT is ignored and leaves no state.
- A late done from a timed-out request that arrives in the WAIT of the next request is accepted. This is a documented limitation; TIMEOUT_CYCLES must exceed the app's worst-case latency.
- Reset asserted in any state returns the FSM to IDLE next cycle and drops out_vld and match_field_vld. A pending request is discarded.
- Back-to-back throughput is 1 packet per 4 cycles when the app answers in the cycle after the request and out_rdy is held high.

Optional Feature:
- Macro: STATE_APP_DISPATCH_STATS_EN.
- Defined: adds three output ports.
  - stat_lookups (32 bits): increments on each ISSUE.
  - stat_timeouts (32 bits): increments on each timeout exit from WAIT.
  - stat_stray_done (32 bits): increments on app_done outside WAIT.
  - All three saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical in both builds.

Test Plan:
- Single packet, app_done one cycle after match_field_vld with app_action=0xA5 pattern, out_rdy=1 -> match_field_vld high exactly 1 cycle; out_vld 3 cycles after the input handshake; out_action=0xA5 pattern; out_timeout=0.
- App never responds, TIMEOUT_CYCLES=64 -> out_vld after the 64th WAIT cycle; out_action=in_action; out_src_port=in_src_port; out_timeout=1.
- app_done on exactly the expiry cycle -> app result is used and out_timeout=0.
- out_rdy held low 10 cycles while in_vld stays high -> out_action stable; in_rdy=0; no second match_field_vld; after out_rdy, the next packet is accepted.
- Stray app_done in IDLE, then normal packet -> stray ignored; correct result returned. With STATS_EN, stat_stray_done=1 and stat_lookups=1.
- Reset asserted mid-WAIT -> next cycle IDLE, in_rdy=1, out_vld=0; subsequent packet completes normally.

Source files
------------

// File: rtl/state_app_dispatcher.sv
// state_app_dispatcher: single-outstanding lookup initiator towards one state app, with timeout pass-through.
// Define STATE_APP_DISPATCH_STATS_EN to add saturating lookup/timeout/stray-done counters.
`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 320
`endif
`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 8
`endif
module state_app_dispatcher #(
  parameter int ST_WIDTH       = 64,
  parameter int ACTION_WIDTH   = `OPENFLOW_ACTION_WIDTH,
  parameter int SRC_PORT_WIDTH = `OPENFLOW_ENTRY_SRC_PORT_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_WIDTH   = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ST_WIDTH-1:0]       in_match_field,
  input  logic [ACTION_WIDTH-1:0]   in_action,
  input  logic [SRC_PORT_WIDTH-1:0] in_src_port,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [ST_WIDTH-1:0]       match_field,
  output logic                      match_field_vld,
  output logic [ACTION_WIDTH-1:0]   action_in,
  output logic [SRC_PORT_WIDTH-1:0] flow_entry_src_port,
  input  logic                      app_done,
  input  logic [ACTION_WIDTH-1:0]   app_action,
  input  logic [SRC_PORT_WIDTH-1:0] app_src_port,
  output logic [ACTION_WIDTH-1:0]   out_action,
  output logic [SRC_PORT_WIDTH-1:0] out_src_port,
  output logic                      out_timeout,
  output logic                      out_vld,
  input  logic                      out_rdy
`ifdef STATE_APP_DISPATCH_STATS_EN
  ,
  output logic [31:0]               stat_lookups,
  output logic [31:0]               stat_timeouts,
  output logic [31:0]               stat_stray_done
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t state;
  logic [ST_WIDTH-1:0] ctx_field;
  logic [ACTION_WIDTH-1:0] ctx_action;
  logic [SRC_PORT_WIDTH-1:0] ctx_port;
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic expired;
  assign expired = to_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign match_field = ctx_field;
  assign action_in = ctx_action;
  assign flow_entry_src_port = ctx_port;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_rdy <= 1'b1;
      match_field_vld <= 1'b0;
      out_vld <= 1'b0;
      out_timeout <= 1'b0;
      out_action <= '0;
      out_src_port <= '0;
      ctx_field <= '0;
      ctx_action <= '0;
      ctx_port <= '0;
      to_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_vld && in_rdy) begin
          ctx_field <= in_match_field;
          ctx_action <= in_action;
          ctx_port <= in_src_port;
          in_rdy <= 1'b0;
          match_field_vld <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          match_field_vld <= 1'b0;
          to_cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          // a done arriving on the expiry cycle still carries a valid result, so it wins
          if (app_done || expired) begin
            out_action <= app_done ? app_action : ctx_action;
            out_src_port <= app_done ? app_src_port : ctx_port;
            out_timeout <= !app_done;
            out_vld <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (out_rdy) begin
          out_vld <= 1'b0;
          in_rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef STATE_APP_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_timeouts <= '0;
      stat_stray_done <= '0;
    end else begin
      if (state == ISSUE && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
      if (state == WAIT && !app_done && expired && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
      if (state != WAIT && app_done && stat_stray_done != '1) stat_stray_done <= stat_stray_done + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_state_app_dispatcher.sv
// tb_state_app_dispatcher: directed stimulus with a queue scoreboard checked by a separate output monitor.
module tb_state_app_dispatcher;
  localparam int SW = 64, AW = 16, PW = 8, TO = 64;
  logic clk = 1'b0, reset = 1'b1;
  logic [SW-1:0] in_match_field = '0, match_field;
  logic [AW-1:0] in_action = '0, action_in, app_action = '0, out_action;
  logic [PW-1:0] in_src_port = '0, flow_entry_src_port, app_src_port = '0, out_src_port;
  logic in_vld = 1'b0, in_rdy, match_field_vld, app_done = 1'b0, out_timeout, out_vld, out_rdy = 1'b1;
`ifdef STATE_APP_DISPATCH_STATS_EN
  logic [31:0] stat_lookups, stat_timeouts, stat_stray_done;
`endif
  state_app_dispatcher #(.ST_WIDTH(SW), .ACTION_WIDTH(AW), .SRC_PORT_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_match_field(in_match_field), .in_action(in_action), .in_src_port(in_src_port),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .match_field(match_field), .match_field_vld(match_field_vld),
    .action_in(action_in), .flow_entry_src_port(flow_entry_src_port),
    .app_done(app_done), .app_action(app_action), .app_src_port(app_src_port),
    .out_action(out_action), .out_src_port(out_src_port), .out_timeout(out_timeout),
    .out_vld(out_vld), .out_rdy(out_rdy)
`ifdef STATE_APP_DISPATCH_STATS_EN
    , .stat_lookups(stat_lookups), .stat_timeouts(stat_timeouts), .stat_stray_done(stat_stray_done)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [AW-1:0] a; logic [PW-1:0] p; logic t;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, mfv_cnt = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (match_field_vld) mfv_cnt++;
    if (!reset && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got output action %0h expected no output", out_action);
      end else begin
        mon_e = sb.pop_front();
        check("out_action", 64'(out_action), 64'(mon_e.a));
        check("out_src_port", 64'(out_src_port), 64'(mon_e.p));
        check("out_timeout", 64'(out_timeout), 64'(mon_e.t));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [SW-1:0] f, input logic [AW-1:0] a, input logic [PW-1:0] p);
    int n = 0;
    in_match_field = f;
    in_action = a;
    in_src_port = p;
    in_vld = 1'b1;
    while (!in_rdy && n < 200) begin
      tick();
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_wait: in_rdy got %0b expected 1", in_rdy);
    end
    tick();
    in_vld = 1'b0;
  endtask
  task automatic complete(input logic [AW-1:0] a, input logic [PW-1:0] p);
    tick();
    app_done = 1'b1;
    app_action = a;
    app_src_port = p;
    sb.push_back({a, p, 1'b0});
    tick();
    app_done = 1'b0;
    check("complete_out_vld", 64'(out_vld), 64'd1);
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time got 100000 expected completion earlier");
    $fatal(1);
  end
  initial begin
    int base;
    tick();
    tick();
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_mfv", 64'(match_field_vld), 64'd0);
    check("rst_out_action", 64'(out_action), 64'd0);
    check("rst_out_timeout", 64'(out_timeout), 64'd0);
    reset = 1'b0;
    tick();
    // single packet, app answers in the cycle after the request
    base = mfv_cnt;
    send(64'h0123_4567_89AB_CDEF, 16'h1111, 8'h22);
    check("t1_mfv_issue", 64'(match_field_vld), 64'd1);
    check("t1_match_field", match_field, 64'h0123_4567_89AB_CDEF);
    check("t1_in_rdy_busy", 64'(in_rdy), 64'd0);
    tick();
    check("t1_mfv_wait", 64'(match_field_vld), 64'd0);
    check("t1_out_vld_wait", 64'(out_vld), 64'd0);
    app_done = 1'b1;
    app_action = 16'h00A5;
    app_src_port = 8'h5A;
    sb.push_back({16'h00A5, 8'h5A, 1'b0});
    tick();
    app_done = 1'b0;
    check("t1_out_vld_lat3", 64'(out_vld), 64'd1);
    tick();
    check("t1_idle_in_rdy", 64'(in_rdy), 64'd1);
    check("t1_idle_out_vld", 64'(out_vld), 64'd0);
    check("t1_mfv_pulses", 64'(mfv_cnt - base), 64'd1);
    // app never responds
    send(64'hAAAA, 16'h1234, 8'h34);
    sb.push_back({16'h1234, 8'h34, 1'b1});
    check("t2_ctx_action", 64'(action_in), 64'h1234);
    check("t2_ctx_port", 64'(flow_entry_src_port), 64'h34);
    tick();
    repeat (TO - 1) tick();
    check("t2_out_vld_wait64", 64'(out_vld), 64'd0);
    tick();
    check("t2_out_vld", 64'(out_vld), 64'd1);
    tick();
    // done on the expiry cycle wins over the timeout
    send(64'hBBBB, 16'h5555, 8'h55);
    tick();
    repeat (TO - 1) tick();
    app_done = 1'b1;
    app_action = 16'hBEEF;
    app_src_port = 8'hC3;
    sb.push_back({16'hBEEF, 8'hC3, 1'b0});
    tick();
    app_done = 1'b0;
    check("t3_out_vld", 64'(out_vld), 64'd1);
    tick();
    // downstream stall with the next packet already offered
    out_rdy = 1'b0;
    send(64'hCCCC, 16'h7777, 8'h77);
    in_vld = 1'b1;
    in_action = 16'h8888;
    in_src_port = 8'h88;
    in_match_field = 64'hDDDD;
    tick();
    app_done = 1'b1;
    app_action = 16'h0F0F;
    app_src_port = 8'h11;
    sb.push_back({16'h0F0F, 8'h11, 1'b0});
    tick();
    app_done = 1'b0;
    base = mfv_cnt;
    for (int i = 0; i < 10; i++) begin
      check("t4_stall_out_vld", 64'(out_vld), 64'd1);
      check("t4_stall_in_rdy", 64'(in_rdy), 64'd0);
      check("t4_stall_action", 64'(out_action), 64'h0F0F);
      tick();
    end
    check("t4_no_second_req", 64'(mfv_cnt - base), 64'd0);
    out_rdy = 1'b1;
    tick();
    send(64'hDDDD, 16'h8888, 8'h88);
    check("t4_next_field", match_field, 64'hDDDD);
    complete(16'h9999, 8'h99);
    // stray done in IDLE is ignored
    do_reset();
`ifdef STATE_APP_DISPATCH_STATS_EN
    check("t5_stat_lookups_rst", 64'(stat_lookups), 64'd0);
`endif
    app_done = 1'b1;
    app_action = 16'hDEAD;
    app_src_port = 8'hDE;
    tick();
    app_done = 1'b0;
    check("t5_stray_out_vld", 64'(out_vld), 64'd0);
    send(64'hEEEE, 16'h4141, 8'h41);
    complete(16'h4242, 8'h42);
`ifdef STATE_APP_DISPATCH_STATS_EN
    check("t5_stat_stray", 64'(stat_stray_done), 64'd1);
    check("t5_stat_lookups", 64'(stat_lookups), 64'd1);
    check("t5_stat_timeouts", 64'(stat_timeouts), 64'd0);
`endif
    // reset in the middle of WAIT discards the request
    send(64'hFFFF, 16'h6060, 8'h60);
    tick();
    tick();
    do_reset();
    check("t6_in_rdy", 64'(in_rdy), 64'd1);
    check("t6_out_vld", 64'(out_vld), 64'd0);
    check("t6_mfv", 64'(match_field_vld), 64'd0);
    send(64'h1234, 16'h6161, 8'h61);
    complete(16'h6262, 8'h62);
    tick();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
